// File: rtl/cc40_frame_sender.sv
// CC-40 frame sender: fetches NUM_BYTES command bytes from the commutator on
// each req rising edge, optionally appends an 8-bit sum, and shifts the frame
// out as UART 8N1 (LSB first) on txd.
module cc40_frame_sender #(
  parameter int CLK_DIV   = 694,
  parameter int NUM_BYTES = 4,
  parameter int CHKSUM_EN = 1,
  parameter int SETTLE    = 4,
  parameter int GAP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] rdData,
  output logic [2:0] numBytes,
  output logic       txd,
  output logic       busy,
  output logic       done,
  output logic       ovr
);

  localparam int TOTAL    = NUM_BYTES + CHKSUM_EN;
  localparam int GAP_CLKS = GAP_BITS * CLK_DIV;
  localparam int CM1      = (CLK_DIV > SETTLE) ? CLK_DIV : SETTLE;
  localparam int CMAX     = (CM1 > GAP_CLKS) ? CM1 : GAP_CLKS;
  localparam int CW       = $clog2(CMAX + 1);
  localparam int IW       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int PW       = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] BIT_LAST    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'((GAP_BITS > 0) ? GAP_CLKS - 1 : 0);

  // The byte-boundary decision (more bytes or finish) is taken in the last
  // clock of STOP/GAP so consecutive bytes stay exactly back-to-back.
  typedef enum logic [3:0] {
    S_IDLE, S_SETTLE, S_ADDR, S_WAIT, S_CAP, S_START, S_DATA, S_STOP, S_GAP
  } state_t;

  state_t                      state, state_nxt;
  logic [2:0]                  sr;
  logic                        req_edge;
  logic [CW-1:0]               cnt;
  logic [IW-1:0]               idx;
  logic [PW-1:0]               ptr;
  logic [2:0]                  bit_idx;
  logic [NUM_BYTES-1:0][7:0]   bytes;
  logic [7:0]                  sum;
  logic [7:0]                  cur_byte;
  logic                        tick, timed, last_idx, more, byte_end;

  assign req_edge = sr[1] & ~sr[2];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next state plus timing strobes for the current state.
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    timed     = 1'b0;
    last_idx  = (idx == IW'(NUM_BYTES - 1));
    more      = (ptr != PW'(TOTAL - 1));
    cur_byte  = (ptr < PW'(NUM_BYTES)) ? bytes[ptr[IW-1:0]] : sum;
    case (state)
      S_SETTLE:                timed = 1'b1;
      S_START, S_DATA, S_STOP: timed = 1'b1;
      S_GAP:                   timed = 1'b1;
      default:                 timed = 1'b0;
    endcase
    case (state)
      S_SETTLE:                tick = (cnt == SETTLE_LAST);
      S_START, S_DATA, S_STOP: tick = (cnt == BIT_LAST);
      S_GAP:                   tick = (cnt == GAP_LAST);
      default:                 tick = 1'b0;
    endcase
    byte_end = tick && ((state == S_STOP && GAP_BITS == 0) || state == S_GAP);
    case (state)
      S_IDLE:   if (req_edge) state_nxt = S_SETTLE;
      S_SETTLE: if (tick) state_nxt = S_ADDR;
      S_ADDR:   state_nxt = S_WAIT;
      S_WAIT:   state_nxt = S_CAP;
      S_CAP:    state_nxt = last_idx ? S_START : S_ADDR;
      S_START:  if (tick) state_nxt = S_DATA;
      S_DATA:   if (tick && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:   if (tick) state_nxt = (GAP_BITS != 0) ? S_GAP : (more ? S_START : S_IDLE);
      S_GAP:    if (tick) state_nxt = more ? S_START : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: req sync, counters, fetch buffer, checksum and txd.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr       <= '0;
      cnt      <= '0;
      idx      <= '0;
      ptr      <= '0;
      bit_idx  <= '0;
      bytes    <= '0;
      sum      <= '0;
      numBytes <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      sr   <= {sr[1:0], req};
      done <= 1'b0;
      if (req_edge && state != S_IDLE) ovr <= 1'b1;
      if (state_nxt != state || tick || !timed) cnt <= '0;
      else                                      cnt <= cnt + CW'(1);
      case (state)
        S_IDLE: if (req_edge) begin
          busy <= 1'b1;
          sum  <= '0;
          idx  <= '0;
        end
        S_SETTLE: if (tick) idx <= '0;
        S_ADDR:   numBytes <= 3'(idx);
        S_CAP: begin
          bytes[idx] <= rdData;
          sum        <= sum + rdData;
          if (last_idx) begin
            numBytes <= '0;
            ptr      <= '0;
            txd      <= 1'b0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_START: if (tick) begin
          txd     <= cur_byte[0];
          bit_idx <= '0;
        end
        S_DATA: if (tick) begin
          if (bit_idx == 3'd7) begin
            txd <= 1'b1;
          end else begin
            txd     <= cur_byte[bit_idx + 3'd1];
            bit_idx <= bit_idx + 3'd1;
          end
        end
        default: ;
      endcase
      if (byte_end) begin
        if (more) begin
          ptr <= ptr + PW'(1);
          txd <= 1'b0;
        end else begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cc40_frame_sender.sv
// Directed bench for cc40_frame_sender: two instances (checksum+gap, and
// no-checksum/no-gap), a registered commutator model per instance, and a
// cycle-exact UART frame checker.
module tb_cc40_frame_sender;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst, req, req5;
  logic [7:0] rd_data, rd_data5;
  logic [2:0] nb, nb5;
  logic       txd, busy, done, ovr;
  logic       txd5, busy5, done5, ovr5;
  logic [7:0] mem  [0:7];
  logic [7:0] mem5 [0:7];
  logic [7:0] exp_b[0:4];
  int nchk = 0, nerr = 0, done_cnt = 0;

  always #5 clk = ~clk;

  cc40_frame_sender #(.CLK_DIV(DIV), .NUM_BYTES(4), .CHKSUM_EN(1), .SETTLE(4), .GAP_BITS(1)) dut (
    .clk(clk), .rst(rst), .req(req), .rdData(rd_data), .numBytes(nb),
    .txd(txd), .busy(busy), .done(done), .ovr(ovr));

  cc40_frame_sender #(.CLK_DIV(DIV), .NUM_BYTES(4), .CHKSUM_EN(0), .SETTLE(4), .GAP_BITS(0)) dut5 (
    .clk(clk), .rst(rst), .req(req5), .rdData(rd_data5), .numBytes(nb5),
    .txd(txd5), .busy(busy5), .done(done5), .ovr(ovr5));

  // Commutator: oData registered from the presented index.
  always @(posedge clk) begin
    rd_data  <= mem[nb];
    rd_data5 <= mem5[nb5];
  end

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  function automatic logic txd_of(input bit sel);
    return sel ? txd5 : txd;
  endfunction
  function automatic logic busy_of(input bit sel);
    return sel ? busy5 : busy;
  endfunction
  function automatic logic done_of(input bit sel);
    return sel ? done5 : done;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    nchk++;
    assert (got === expv) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic pulse_req(input int hold);
    req = 1'b1;
    fork
      begin
        repeat (hold) @(negedge clk);
        req = 1'b0;
      end
    join_none
  endtask

  task automatic set_mem(input logic [7:0] a, b, c, d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  task automatic set_exp(input logic [7:0] a, b, c, d, e);
    exp_b[0] = a; exp_b[1] = b; exp_b[2] = c; exp_b[3] = d; exp_b[4] = e;
  endtask

  // Waits for a start bit, then checks every clock of the byte (and gap)
  // against the expected level with busy held high. Optionally raises req
  // for 4 clocks starting at cycle 'poke' of the byte.
  task automatic rx_byte(input bit sel, input logic [7:0] b, input int gap,
                         input string tag, input int poke, output int waited);
    int t = 0;
    int bad = 0;
    logic [10:0] fr;
    fr = {2'b11, b, 1'b0};
    while (txd_of(sel) !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    waited = t;
    check({tag, "_start_seen"}, (t < 3000), 1);
    for (int k = 0; k < 10 + gap; k++) begin
      for (int c = 0; c < DIV; c++) begin
        if (poke >= 0 && k * DIV + c == poke)     req = 1'b1;
        if (poke >= 0 && k * DIV + c == poke + 4) req = 1'b0;
        if (txd_of(sel) !== fr[k] || busy_of(sel) !== 1'b1) bad++;
        @(negedge clk);
      end
    end
    check({tag, "_bits"}, bad, 0);
  endtask

  task automatic rx_frame(input bit sel, input int n, input int gap, input string tag,
                          input int poke_byte, input int poke_cyc);
    int t;
    for (int b = 0; b < n; b++) begin
      rx_byte(sel, exp_b[b], gap, $sformatf("%s_b%0d", tag, b),
              (b == poke_byte) ? poke_cyc : -1, t);
      if (b > 0) check($sformatf("%s_b%0d_contig", tag, b), t, 0);
    end
    check({tag, "_done"}, done_of(sel), 1);
    check({tag, "_busy_end"}, busy_of(sel), 0);
  endtask

  task automatic quiet(input int n, input string tag);
    int bad = 0;
    repeat (n) begin
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check(tag, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int t;
    logic [2:0] enb;
    rst = 1'b0; req = 1'b0; req5 = 1'b0;
    for (int i = 0; i < 8; i++) begin mem[i] = 8'h00; mem5[i] = 8'h00; end
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovr", ovr, 0);
    check("rst_nb", nb, 0);
    check("rst_txd5", txd5, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 1: basic frame with checksum 0x4A
    set_mem(8'd50, 8'd21, 8'd0, 8'd3);
    set_exp(8'h32, 8'h15, 8'h00, 8'h03, 8'h4A);
    d0 = done_cnt;
    pulse_req(20);
    rx_frame(0, 5, 1, "t1", -1, -1);
    check("t1_ovr", ovr, 0);
    quiet(10, "t1_quiet");
    check("t1_done_once", done_cnt - d0, 1);

    // 2: index sequence and capture timing, memory rewritten after fetch
    set_mem(8'd50, 8'd22, 8'd0, 8'd46);
    set_exp(8'h32, 8'h16, 8'h00, 8'h2E, 8'h76);
    req = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      if (n == 4) req = 1'b0;
      if (n >= 11 && n <= 13)      enb = 3'd1;
      else if (n >= 14 && n <= 16) enb = 3'd2;
      else if (n >= 17 && n <= 18) enb = 3'd3;
      else                         enb = 3'd0;
      check($sformatf("t2_nb_%0d", n), nb, enb);
      if (n == 2) check("t2_busy_pre", busy, 0);
      if (n == 3) check("t2_busy_on", busy, 1);
    end
    set_mem(8'hEE, 8'hEE, 8'hEE, 8'hEE);
    rx_frame(0, 5, 1, "t2", -1, -1);
    quiet(10, "t2_quiet");

    // 3: overrun during byte 2
    set_mem(8'd50, 8'd21, 8'd0, 8'd3);
    set_exp(8'h32, 8'h15, 8'h00, 8'h03, 8'h4A);
    d0 = done_cnt;
    pulse_req(3);
    rx_frame(0, 5, 1, "t3", 2, 16);
    check("t3_ovr_set", ovr, 1);
    quiet(60, "t3_no_second");
    check("t3_done_once", done_cnt - d0, 1);
    check("t3_ovr_sticky", ovr, 1);
    set_mem(8'd1, 8'd2, 8'd3, 8'd4);
    set_exp(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
    pulse_req(3);
    rx_frame(0, 5, 1, "t3b", -1, -1);
    check("t3b_ovr", ovr, 1);

    // 4: reset during data of byte 1
    set_mem(8'd50, 8'd21, 8'd0, 8'd3);
    pulse_req(3);
    rx_byte(0, 8'h32, 1, "t4_b0", -1, t);
    repeat (9) @(negedge clk);
    check("t4_pre_txd", txd, 0);
    d0 = done_cnt;
    rst = 1'b0;
    @(negedge clk);
    check("t4_txd", txd, 1);
    check("t4_busy", busy, 0);
    check("t4_ovr", ovr, 0);
    check("t4_nb", nb, 0);
    rst = 1'b1;
    quiet(40, "t4_quiet");
    check("t4_no_done", done_cnt - d0, 0);
    set_mem(8'h5A, 8'hA5, 8'h0F, 8'hF0);
    set_exp(8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'hFE);
    pulse_req(3);
    rx_frame(0, 5, 1, "t4b", -1, -1);
    quiet(10, "t4b_quiet");

    // 5: no checksum, no gap, back-to-back bytes
    mem5[0] = 8'd50; mem5[1] = 8'd21; mem5[2] = 8'd0; mem5[3] = 8'd3;
    set_exp(8'h32, 8'h15, 8'h00, 8'h03, 8'h00);
    req5 = 1'b1;
    repeat (3) @(negedge clk);
    req5 = 1'b0;
    rx_frame(1, 4, 0, "t5", -1, -1);
    @(negedge clk);
    check("t5_done_pulse", done5, 0);

    // 6: checksum wrap and long req
    set_mem(8'hFF, 8'hFF, 8'hFF, 8'h04);
    set_exp(8'hFF, 8'hFF, 8'hFF, 8'h04, 8'h01);
    d0 = done_cnt;
    pulse_req(300);
    rx_frame(0, 5, 1, "t6", -1, -1);
    quiet(100, "t6_quiet");
    check("t6_done_once", done_cnt - d0, 1);
    check("t6_ovr", ovr, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
